// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor: branch condition codes,
// direction-counter constants and the default BTB entry layout.
package branch_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'd0,
    F3_BNE  = 3'd1,
    F3_BLT  = 3'd4,
    F3_BGE  = 3'd5,
    F3_BLTU = 3'd6,
    F3_BGEU = 3'd7
  } funct3_e;

  localparam int DEF_XLEN        = 32;
  localparam int DEF_BTB_ENTRIES = 64;
  localparam int DEF_CNT_W       = 2;
  localparam int DEF_IDX_W       = $clog2(DEF_BTB_ENTRIES);
  localparam int DEF_TAG_W       = DEF_XLEN - DEF_IDX_W - 2;

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_XLEN-1:0]  target;
    logic [DEF_CNT_W-1:0] cnt;
  } btb_entry_t;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int cnt_weak_taken(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int cnt_weak_not_taken(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (fetch, execute),
// one synchronous write port, asynchronous clear on reset.
module btb_table #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int CNT_W    = 2,
  parameter int CNT_INIT = 1,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] f_idx_i,
  output logic             f_valid_o,
  output logic [TAG_W-1:0] f_tag_o,
  output logic [XLEN-1:0]  f_target_o,
  output logic [CNT_W-1:0] f_cnt_o,
  input  logic [IDX_W-1:0] ex_idx_i,
  output logic             ex_valid_o,
  output logic [TAG_W-1:0] ex_tag_o,
  output logic [XLEN-1:0]  ex_target_o,
  output logic [CNT_W-1:0] ex_cnt_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [XLEN-1:0]  wr_target_i,
  input  logic [CNT_W-1:0] wr_cnt_i
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  // Reads see pre-write contents; a same-cycle write lands at the edge.
  assign f_valid_o   = valid_q[f_idx_i];
  assign f_tag_o     = tag_q[f_idx_i];
  assign f_target_o  = target_q[f_idx_i];
  assign f_cnt_o     = cnt_q[f_idx_i];
  assign ex_valid_o  = valid_q[ex_idx_i];
  assign ex_tag_o    = tag_q[ex_idx_i];
  assign ex_target_o = target_q[ex_idx_i];
  assign ex_cnt_o    = cnt_q[ex_idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_W'(CNT_INIT);
      end
    end else if (we_i) begin
      valid_q[wr_idx_i]  <= 1'b1;
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
      cnt_q[wr_idx_i]    <= wr_cnt_i;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// RV32I branch resolution with a direct-mapped BTB, registered redirect pulse
// and branch/mispredict performance counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int CNT_W       = 2,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   f_pc,
  output logic              f_pred_taken,
  output logic [XLEN-1:0]   f_pred_target,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic              ex_taken,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WT   = CNT_W'(cnt_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WNT  = CNT_W'(cnt_weak_not_taken(CNT_W));
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  logic             f_hit_valid, ex_hit_valid;
  logic [TAG_W-1:0] f_rd_tag, ex_rd_tag;
  logic [XLEN-1:0]  f_rd_target, ex_rd_target;
  logic [CNT_W-1:0] f_rd_cnt, ex_rd_cnt;
  logic             f_hit, ex_hit;

  logic             we;
  logic [XLEN-1:0]  wr_target;
  logic [CNT_W-1:0] wr_cnt;

  btb_table #(
    .XLEN     (XLEN),
    .ENTRIES  (BTB_ENTRIES),
    .CNT_W    (CNT_W),
    .CNT_INIT (int'(CNT_WNT))
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_idx_i     (f_pc[IDX_W+1:2]),
    .f_valid_o   (f_hit_valid),
    .f_tag_o     (f_rd_tag),
    .f_target_o  (f_rd_target),
    .f_cnt_o     (f_rd_cnt),
    .ex_idx_i    (ex_pc[IDX_W+1:2]),
    .ex_valid_o  (ex_hit_valid),
    .ex_tag_o    (ex_rd_tag),
    .ex_target_o (ex_rd_target),
    .ex_cnt_o    (ex_rd_cnt),
    .we_i        (we),
    .wr_idx_i    (ex_pc[IDX_W+1:2]),
    .wr_tag_i    (ex_pc[XLEN-1:IDX_W+2]),
    .wr_target_i (wr_target),
    .wr_cnt_i    (wr_cnt)
  );

  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[1:0], ex_pc[1:0]};

  assign f_hit         = f_hit_valid && (f_rd_tag == f_pc[XLEN-1:IDX_W+2]);
  assign ex_hit        = ex_hit_valid && (ex_rd_tag == ex_pc[XLEN-1:IDX_W+2]);
  assign f_pred_taken  = f_hit && f_rd_cnt[CNT_W-1];
  assign f_pred_target = f_hit ? f_rd_target : f_pc + PC_STEP;

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic cond, br_ok, resolving, mispred_d;
  logic [XLEN-1:0] restart_pc;

  assign rs1_s = ex_rs1;
  assign rs2_s = ex_rs2;

  always_comb begin
    cond  = 1'b0;
    br_ok = 1'b1;
    case (funct3_e'(ex_funct3))
      F3_BEQ:  cond = (ex_rs1 == ex_rs2);
      F3_BNE:  cond = (ex_rs1 != ex_rs2);
      F3_BLT:  cond = (rs1_s < rs2_s);
      F3_BGE:  cond = (rs1_s >= rs2_s);
      F3_BLTU: cond = (ex_rs1 < ex_rs2);
      F3_BGEU: cond = (ex_rs1 >= ex_rs2);
      default: br_ok = 1'b0;
    endcase
  end

  // Jumps win over branches; reserved funct3 codes are invisible to the predictor.
  assign resolving  = ex_valid && (ex_jump || (ex_branch && br_ok));
  assign ex_taken   = ex_valid && (ex_jump || (ex_branch && br_ok && cond));
  assign mispred_d  = resolving &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
  assign restart_pc = ex_taken ? ex_target : ex_pc + PC_STEP;

  always_comb begin
    we        = 1'b0;
    wr_target = ex_rd_target;
    wr_cnt    = ex_rd_cnt;
    if (resolving) begin
      if (ex_hit) begin
        we     = 1'b1;
        wr_cnt = ex_taken ? cnt_sat_inc(ex_rd_cnt) : cnt_sat_dec(ex_rd_cnt);
        if (ex_taken) wr_target = ex_target;
      end else if (ex_taken) begin
        we        = 1'b1;
        wr_target = ex_target;
        wr_cnt    = ex_jump ? CNT_MAX : CNT_WT;
      end
    end
  end

  logic              mispredict_q;
  logic [XLEN-1:0]   redirect_q;
  logic [PERF_W-1:0] perf_br_q, perf_mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      perf_br_q    <= '0;
      perf_mp_q    <= '0;
    end else begin
      mispredict_q <= mispred_d;
      if (mispred_d) redirect_q <= restart_pc;
      if (resolving) perf_br_q <= perf_br_q + PERF_W'(1);
      if (mispred_d) perf_mp_q <= perf_mp_q + PERF_W'(1);
    end
  end

  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_q;
  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        ex_valid, ex_branch, ex_jump;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_target, ex_pred_target;
  logic        ex_pred_taken;
  logic        ex_taken, mispredict;
  logic [31:0] redirect_pc, perf_branches, perf_mispredicts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .XLEN(32), .BTB_ENTRIES(64), .CNT_W(2), .PERF_W(32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .f_pc             (f_pc),
    .f_pred_taken     (f_pred_taken),
    .f_pred_target    (f_pred_target),
    .ex_valid         (ex_valid),
    .ex_branch        (ex_branch),
    .ex_jump          (ex_jump),
    .ex_funct3        (ex_funct3),
    .ex_pc            (ex_pc),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_taken         (ex_taken),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0;
  endtask

  // Present a resolve; combinational outputs are valid 1 ns later.
  task automatic drive(input logic [31:0] pc, input logic [2:0] f3, input logic br,
                       input logic jmp, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_branch = br; ex_jump = jmp; ex_funct3 = f3;
    ex_pc = pc; ex_rs1 = a; ex_rs2 = b; ex_target = tgt;
    ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_t, input logic [31:0] exp_tgt);
    f_pc = pc;
    #1;
    check({tag, "_taken"}, 64'(f_pred_taken), 64'(exp_t));
    check({tag, "_target"}, 64'(f_pred_target), 64'(exp_tgt));
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;

  vec_t vecs[13] = '{
    '{3'd0, 32'h5, 32'h5, 1'b1}, '{3'd0, 32'h5, 32'h6, 1'b0},
    '{3'd1, 32'h5, 32'h6, 1'b1}, '{3'd1, 32'h5, 32'h5, 1'b0},
    '{3'd4, 32'hFFFFFFFF, 32'h1, 1'b1}, '{3'd4, 32'h1, 32'hFFFFFFFF, 1'b0},
    '{3'd5, 32'h1, 32'hFFFFFFFF, 1'b1}, '{3'd5, 32'h5, 32'h5, 1'b1},
    '{3'd6, 32'hFFFFFFFF, 32'h1, 1'b0}, '{3'd6, 32'h1, 32'hFFFFFFFF, 1'b1},
    '{3'd7, 32'h1, 32'hFFFFFFFF, 1'b0}, '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1},
    '{3'd3, 32'h1, 32'h2, 1'b0}
  };

  initial begin
    rst_n = 1'b0;
    f_pc = 32'h100;
    ex_funct3 = 3'd0; ex_pc = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    lookup("rst_lookup", 32'h100, 1'b0, 32'h104);
    tick();
    check("rst_mispredict", 64'(mispredict), 64'd0);
    check("rst_perf_br", 64'(perf_branches), 64'd0);
    check("rst_perf_mp", 64'(perf_mispredicts), 64'd0);

    // bltu 1 < 0xFFFFFFFF: taken, miss allocates weakly taken
    drive(32'h100, 3'd6, 1'b1, 1'b0, 32'h1, 32'hFFFFFFFF, 32'h200, 1'b0, 32'h0);
    check("bltu_taken", 64'(ex_taken), 64'd1);
    tick(); idle();
    check("bltu_mispredict", 64'(mispredict), 64'd1);
    check("bltu_redirect", 64'(redirect_pc), 64'h200);
    lookup("bltu_alloc", 32'h100, 1'b1, 32'h200);
    tick();
    check("pulse_one_cycle", 64'(mispredict), 64'd0);

    // bge -1 >= 1 signed: not taken, predicted taken
    drive(32'h100, 3'd5, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h180, 1'b1, 32'h200);
    check("bge_taken", 64'(ex_taken), 64'd0);
    tick(); idle();
    check("bge_mispredict", 64'(mispredict), 64'd1);
    check("bge_redirect", 64'(redirect_pc), 64'h104);
    lookup("bge_dec", 32'h100, 1'b0, 32'h200);

    // Four taken resolves saturate the counter at 3
    for (int i = 0; i < 4; i++) begin
      drive(32'h100, 3'd0, 1'b1, 1'b0, 32'h5, 32'h5, 32'h200, 1'b1, 32'h200);
      tick(); idle();
      check("sat_taken_nomp", 64'(mispredict), 64'd0);
    end
    lookup("sat_up", 32'h100, 1'b1, 32'h200);
    // Not-taken resolves walk it back: 3->2 (taken), 2->1 and 1->0 (not taken)
    for (int i = 0; i < 3; i++) begin
      drive(32'h100, 3'd1, 1'b1, 1'b0, 32'h5, 32'h5, 32'h200, 1'b1, 32'h200);
      tick(); idle();
      check("sat_nt_mp", 64'(mispredict), 64'd1);
      lookup("sat_down", 32'h100, (i == 0), 32'h200);
    end

    // Bring 0x100 back to predicting taken (0->1->2)
    for (int i = 0; i < 2; i++) begin
      drive(32'h100, 3'd0, 1'b1, 1'b0, 32'h7, 32'h7, 32'h200, 1'b1, 32'h200);
      tick(); idle();
    end
    lookup("alias_base", 32'h100, 1'b1, 32'h200);
    // 0x200 shares index 0 with 0x100 but differs in tag
    lookup("alias_miss", 32'h200, 1'b0, 32'h204);
    drive(32'h200, 3'd0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h300, 1'b0, 32'h0);
    check("jal_taken", 64'(ex_taken), 64'd1);
    tick(); idle();
    check("jal_mispredict", 64'(mispredict), 64'd1);
    check("jal_redirect", 64'(redirect_pc), 64'h300);
    lookup("alias_new", 32'h200, 1'b1, 32'h300);
    lookup("alias_old_gone", 32'h100, 1'b0, 32'h104);

    // Reserved funct3=2: ignored entirely even if predicted taken
    drive(32'h100, 3'd2, 1'b1, 1'b0, 32'h5, 32'h5, 32'h400, 1'b1, 32'h400);
    check("f3_2_taken", 64'(ex_taken), 64'd0);
    tick(); idle();
    check("f3_2_mispredict", 64'(mispredict), 64'd0);
    check("perf_br", 64'(perf_branches), 64'd12);
    check("perf_mp", 64'(perf_mispredicts), 64'd6);

    // Invalid instruction resolves nothing
    ex_valid = 1'b0; ex_branch = 1'b1; ex_funct3 = 3'd0; ex_rs1 = 32'h1; ex_rs2 = 32'h1;
    #1 check("invalid_taken", 64'(ex_taken), 64'd0);
    idle();

    // Condition table at an otherwise unused PC
    foreach (vecs[i]) begin
      drive(32'h804, vecs[i].f3, 1'b1, 1'b0, vecs[i].a, vecs[i].b, 32'h900, 1'b0, 32'h0);
      check($sformatf("cond_f3_%0d_%0d", vecs[i].f3, i), 64'(ex_taken), 64'(vecs[i].exp));
      tick(); idle();
    end

    // Jump wins over a reserved-funct3 branch
    drive(32'h808, 3'd2, 1'b1, 1'b1, 32'h0, 32'h0, 32'hA00, 1'b0, 32'h0);
    check("jump_priority", 64'(ex_taken), 64'd1);
    tick(); idle();
    check("prio_mispredict", 64'(mispredict), 64'd1);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check("async_mispredict", 64'(mispredict), 64'd0);
    check("async_redirect", 64'(redirect_pc), 64'd0);
    check("async_perf_br", 64'(perf_branches), 64'd0);
    check("async_perf_mp", 64'(perf_mispredicts), 64'd0);
    lookup("async_btb", 32'h200, 1'b0, 32'h204);
    @(negedge clk) rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
